ahb2apb_multi_bridge: RTL and testbench
=======================================

AHB2APB_MULTI_BRIDGE -- requirements
Module: ahb2apb_multi_bridge

Interface
REQ-001 Parameter SHALL be: NUM_SLV, default 4, number of APB slaves (1..16).
REQ-002 Parameter SHALL be: SLV_ABITS, default 12, per-slave address window in bits; slave index = HADDR[SLV_ABITS+3:SLV_ABITS].
REQ-003 Parameter SHALL be: TIMEOUT, default 256, maximum ACCESS cycles with PREADY low; 0 disables the timeout.
REQ-004 Port SHALL be: HCLK  in  1  single clock, rising edge.
REQ-005 Port SHALL be: HRESET  in  1  reset, synchronous, active-high.
REQ-006 Ports SHALL be: HSEL in 1; HADDR in 32; HTRANS in 2; HWRITE in 1; HSIZE in 3; HWDATA in 32; HREADY in 1 (bus ready).
REQ-007 Ports SHALL be: HREADYOUT out 1; HRESP out 2 (00 OKAY, 01 ERROR); HRDATA out 32.
REQ-008 Ports SHALL be: PADDR out 32; PSEL out NUM_SLV one-hot; PENABLE out 1; PWRITE out 1; PWDATA out 32; PSTRB out 4.
REQ-009 Ports SHALL be: PRDATA in NUM_SLV*32 (slave i at bits 32i+31:32i); PREADY in NUM_SLV; PSLVERR in NUM_SLV.

Function
REQ-010 A transfer SHALL be accepted on a rising edge where HSEL=1, HREADY=1, HTRANS[1]=1 and state is IDLE or ERR2; HTRANS BUSY/IDLE SHALL be ignored.
REQ-011 On acceptance, HADDR, HWRITE, HSIZE and slave index SHALL be registered; state -> LATCH.
REQ-012 States SHALL be IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2; HREADYOUT=1 only in IDLE and ERR2; registered outputs only.
REQ-013 LATCH: capture HWDATA into PWDATA; if slave index >= NUM_SLV or HSIZE > 3'b010 or address misaligned for HSIZE -> ERR1, no PSEL asserted; else -> SETUP.
REQ-014 SETUP: PSEL[idx]=1, PENABLE=0, PADDR=registered HADDR, PWRITE valid; -> ACCESS unconditionally.
REQ-015 ACCESS: PSEL[idx]=1, PENABLE=1; on PREADY[idx]=1 and PSLVERR[idx]=0 -> IDLE, HRDATA <= PRDATA slice idx when read; on PREADY[idx]=1 and PSLVERR[idx]=1 -> ERR1.
REQ-016 Timeout counter SHALL clear on SETUP entry and increment each ACCESS cycle with PREADY[idx]=0; when count reaches TIMEOUT-1 (TIMEOUT>0) -> ERR1, PSEL/PENABLE dropped next cycle.
REQ-017 ERR1: HREADYOUT=0, HRESP=01, PSEL=0; -> ERR2. ERR2: HREADYOUT=1, HRESP=01; -> IDLE, or LATCH if a transfer is accepted.
REQ-018 PSTRB on writes: byte -> 1<<HADDR[1:0]; halfword -> 4'b0011 or 4'b1100 by HADDR[1]; word -> 4'b1111; reads -> 4'b0000.
REQ-019 Zero-wait OKAY transfer latency SHALL be: accept edge n, HREADYOUT=0 in cycles n+1..n+3, HREADYOUT=1 with valid HRDATA in cycle n+4.
REQ-020 Back-to-back: a transfer presented while HREADYOUT=1 completes a prior one SHALL be accepted on that edge with no idle gap.
REQ-021 PSEL and PENABLE SHALL be 0 outside SETUP/ACCESS; PADDR/PWDATA/PWRITE SHALL hold until the next SETUP.
REQ-022 HRDATA SHALL hold its last value after a write or error.

Reset
REQ-023 HRESET=1 on an edge SHALL force IDLE, timeout counter 0, HREADYOUT=1, HRESP=00, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0.
REQ-024 Reset during SETUP/ACCESS SHALL abandon the transfer; PSEL/PENABLE SHALL be 0 in the cycle after the reset edge.

Verification
REQ-025 Write HADDR=0x0000_1004, HSIZE=010, HWDATA=0xA5A5_1234, slave 1 PREADY=1 -> PSEL=4'b0010, PSTRB=4'b1111, PWDATA=0xA5A5_1234, HREADYOUT high at accept+4, HRESP=00.
REQ-026 Read HADDR=0x0000_3000, slave 3 PREADY low 3 ACCESS cycles, PRDATA=0xDEAD_BEEF -> HRDATA=0xDEAD_BEEF, HREADYOUT high at accept+7.
REQ-027 Byte write HADDR=0x0000_0002 -> PSTRB=4'b0100; halfword HADDR=0x0000_0001 -> ERR1/ERR2 sequence, no PSEL.
REQ-028 HADDR=0x0000_5000 (index 5, NUM_SLV=4) -> no PSEL, HRESP=01 with HREADYOUT 0 then 1; slave 2 PSLVERR=1 with PREADY=1 -> same two-cycle ERROR.
REQ-029 TIMEOUT=8, PREADY held low -> PSEL dropped after 8 ACCESS cycles, two-cycle ERROR; reset asserted mid-ACCESS -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ahb2apb_multi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ahb2apb_multi_bridge
//  Purpose  : AHB-Lite slave to multi-slave APB bridge with registered
//             outputs, alignment/size/index checking and an ACCESS timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb2apb_multi_bridge #(
    parameter int NUM_SLV   = 4,
    parameter int SLV_ABITS = 12,
    parameter int TIMEOUT   = 256
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic [1:0]              HRESP,
    output logic [31:0]             HRDATA,
    output logic [31:0]             PADDR,
    output logic [NUM_SLV-1:0]      PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [31:0]             PWDATA,
    output logic [3:0]              PSTRB,
    input  logic [NUM_SLV*32-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]      PREADY,
    input  logic [NUM_SLV-1:0]      PSLVERR
);

    // Counter only needs to reach TIMEOUT-1
    localparam int                 c_CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [4:0]         c_NUM_SLV = 5'(NUM_SLV);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t               r_state, w_next;
    logic [31:0]          r_haddr;
    logic                 r_hwrite;
    logic [2:0]           r_hsize;
    logic [3:0]           r_idx;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 r_hreadyout, r_penable, r_pwrite;
    logic [1:0]           r_hresp;
    logic [31:0]          r_hrdata, r_paddr, r_pwdata;
    logic [NUM_SLV-1:0]   r_psel;
    logic [3:0]           r_pstrb;

    logic                 w_accept, w_lat_err, w_timeout;
    logic                 w_pready, w_pslverr;
    logic [31:0]          w_prdata;
    logic [NUM_SLV-1:0]   w_sel_oh;
    logic [3:0]           w_strb;
    logic                 w_unused;

    // HTRANS[0] only distinguishes NONSEQ/SEQ, which the bridge treats alike
    assign w_unused = HTRANS[0];

    assign w_accept  = HSEL && HREADY && HTRANS[1] &&
                       ((r_state == S_IDLE) || (r_state == S_ERR2));
    assign w_lat_err = ({1'b0, r_idx} >= c_NUM_SLV) || (r_hsize > 3'b010) ||
                       ((r_hsize == 3'b001) && r_haddr[0]) ||
                       ((r_hsize == 3'b010) && (r_haddr[1:0] != 2'b00));
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

    // Route the addressed slave's response and build its one-hot select
    always_comb begin
        w_sel_oh  = '0;
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == 4'(i)) begin
                w_sel_oh[i] = 1'b1;
                w_pready    = PREADY[i];
                w_pslverr   = PSLVERR[i];
                w_prdata    = PRDATA[32*i +: 32];
            end
        end
    end

    // Byte lanes from size and low address bits; reads drive no strobes
    always_comb begin
        w_strb = 4'b0000;
        if (r_hwrite) begin
            case (r_hsize)
                3'b000:  w_strb = 4'b0001 << r_haddr[1:0];
                3'b001:  w_strb = r_haddr[1] ? 4'b1100 : 4'b0011;
                default: w_strb = 4'b1111;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_LATCH;
            S_LATCH:  w_next = w_lat_err ? S_ERR1 : S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: begin
                if (w_pready)       w_next = w_pslverr ? S_ERR1 : S_IDLE;
                else if (w_timeout) w_next = S_ERR1;
            end
            S_ERR1:   w_next = S_ERR2;
            S_ERR2:   w_next = w_accept ? S_LATCH : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Address-phase capture on transfer acceptance
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
            r_hsize  <= '0;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_haddr  <= HADDR;
            r_hwrite <= HWRITE;
            r_hsize  <= HSIZE;
            r_idx    <= HADDR[SLV_ABITS+3:SLV_ABITS];
        end
    end

    // Wait-state counter: cleared entering SETUP, counts stalled ACCESS cycles
    always_ff @(posedge HCLK) begin
        if (HRESET)
            r_cnt <= '0;
        else if ((r_state == S_LATCH) && (w_next == S_SETUP))
            r_cnt <= '0;
        else if ((r_state == S_ACCESS) && !w_pready)
            r_cnt <= r_cnt + 1'b1;
    end

    // Registered bus outputs decoded from the upcoming state
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
            r_hrdata    <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
        end else begin
            r_hreadyout <= (w_next == S_IDLE) || (w_next == S_ERR2);
            r_hresp     <= ((w_next == S_ERR1) || (w_next == S_ERR2)) ? 2'b01 : 2'b00;
            r_psel      <= ((w_next == S_SETUP) || (w_next == S_ACCESS)) ? w_sel_oh : '0;
            r_penable   <= (w_next == S_ACCESS);
            if (r_state == S_LATCH)
                r_pwdata <= HWDATA;
            if ((r_state == S_LATCH) && (w_next == S_SETUP)) begin
                r_paddr  <= r_haddr;
                r_pwrite <= r_hwrite;
                r_pstrb  <= w_strb;
            end
            if ((r_state == S_ACCESS) && w_pready && !w_pslverr && !r_hwrite)
                r_hrdata <= w_prdata;
        end
    end

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign HRDATA    = r_hrdata;
    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_multi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ahb2apb_multi_bridge
//  Purpose  : Scoreboard bench for ahb2apb_multi_bridge (NUM_SLV=4,
//             SLV_ABITS=12, TIMEOUT=8) with a simple APB slave model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb2apb_multi_bridge;

    logic         HCLK = 1'b0;
    logic         HRESET, HSEL, HWRITE, HREADY;
    logic [31:0]  HADDR, HWDATA;
    logic [1:0]   HTRANS;
    logic [2:0]   HSIZE;
    logic         HREADYOUT, PENABLE, PWRITE;
    logic [1:0]   HRESP;
    logic [31:0]  HRDATA, PADDR, PWDATA;
    logic [3:0]   PSEL, PSTRB;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY  = 4'b0000;
    logic [3:0]   PSLVERR;

    ahb2apb_multi_bridge #(.NUM_SLV(4), .SLV_ABITS(12), .TIMEOUT(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        int          low;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } ahb_exp_t;

    typedef struct {
        string       name;
        logic [3:0]  psel;
        logic [31:0] paddr;
        logic        pwrite;
        logic [3:0]  pstrb;
        logic [31:0] pwdata;
    } apb_exp_t;

    ahb_exp_t ahb_q[$];
    apb_exp_t apb_q[$];
    ahb_exp_t mon_a;
    apb_exp_t mon_p;
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // APB slave model: PREADY after slv_wait stalled ACCESS cycles
    int slv_wait = 0;
    int acc_cnt  = 0;
    int acc_len  = 0;
    always @(negedge HCLK) begin
        if ((PSEL != 4'b0000) && PENABLE) begin
            PREADY = (acc_cnt >= slv_wait) ? 4'b1111 : 4'b0000;
            acc_cnt++;
        end else begin
            if (acc_cnt > 0) acc_len = acc_cnt;
            acc_cnt = 0;
            PREADY  = 4'b0000;
        end
    end

    // AHB monitor: on each completion (HREADYOUT rising) check against the queue
    int         low_cnt = 0;
    logic [1:0] last_low_resp = 2'b00;
    always @(negedge HCLK) begin
        if (HRESET) begin
            low_cnt = 0;
        end else if (!HREADYOUT) begin
            low_cnt++;
            last_low_resp = HRESP;
        end else if (low_cnt > 0) begin
            if (ahb_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL ahb_unexpected_done: got completion after %0d wait cycles, expected none", low_cnt);
            end else begin
                mon_a = ahb_q.pop_front();
                chk({mon_a.name, "/wait_cycles"}, low_cnt, mon_a.low);
                chk({mon_a.name, "/resp_last_wait"}, {30'd0, last_low_resp}, {30'd0, mon_a.resp});
                chk({mon_a.name, "/resp"}, {30'd0, HRESP}, {30'd0, mon_a.resp});
                chk({mon_a.name, "/hrdata"}, HRDATA, mon_a.rdata);
            end
            low_cnt = 0;
        end
    end

    // APB monitor: every SETUP cycle must match a queued expectation
    always @(negedge HCLK) begin
        if (!HRESET && (PSEL != 4'b0000) && !PENABLE) begin
            if (apb_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL apb_unexpected_setup: got PSEL=%b PADDR=0x%08h, expected no select", PSEL, PADDR);
            end else begin
                mon_p = apb_q.pop_front();
                chk({mon_p.name, "/psel"}, {28'd0, PSEL}, {28'd0, mon_p.psel});
                chk({mon_p.name, "/paddr"}, PADDR, mon_p.paddr);
                chk({mon_p.name, "/pwrite"}, {31'd0, PWRITE}, {31'd0, mon_p.pwrite});
                chk({mon_p.name, "/pstrb"}, {28'd0, PSTRB}, {28'd0, mon_p.pstrb});
                if (mon_p.pwrite)
                    chk({mon_p.name, "/pwdata"}, PWDATA, mon_p.pwdata);
            end
        end
    end

    // One AHB transfer; returns in the completion cycle so calls chain back-to-back
    task automatic xfer(input string name, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input int low, input logic [1:0] resp, input logic [31:0] rdata,
                        input logic apb, input logic [3:0] psel, input logic [3:0] pstrb);
        ahb_exp_t a;
        apb_exp_t p;
        int guard;
        a.name = name; a.low = low; a.resp = resp; a.rdata = rdata;
        ahb_q.push_back(a);
        if (apb) begin
            p.name = name; p.psel = psel; p.paddr = addr; p.pwrite = wr;
            p.pstrb = pstrb; p.pwdata = wdata;
            apb_q.push_back(p);
        end
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
        guard = 0;
        while (!HREADYOUT && guard < 60) begin
            @(posedge HCLK); #1;
            guard++;
        end
        if (!HREADYOUT) begin
            n_total++;
            n_bad++;
            $display("FAIL %s/stall: got HREADYOUT=0 after 60 cycles, expected 1", name);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/hreadyout"}, {31'd0, HREADYOUT}, 32'd1);
        chk({tag, "/hresp"}, {30'd0, HRESP}, 32'd0);
        chk({tag, "/hrdata"}, HRDATA, 32'd0);
        chk({tag, "/psel"}, {28'd0, PSEL}, 32'd0);
        chk({tag, "/penable"}, {31'd0, PENABLE}, 32'd0);
        chk({tag, "/pwrite"}, {31'd0, PWRITE}, 32'd0);
        chk({tag, "/paddr"}, PADDR, 32'd0);
        chk({tag, "/pwdata"}, PWDATA, 32'd0);
        chk({tag, "/pstrb"}, {28'd0, PSTRB}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        apb_exp_t p;
        int g;
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b000; HWDATA = '0; HREADY = 1'b1; PSLVERR = 4'b0000;
        PRDATA = {32'hDEAD_BEEF, 32'h2222_5555, 32'h1111_6666, 32'h0000_7777};
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk_reset_outputs("reset");
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        slv_wait = 0;
        xfer("wr_word", 32'h0000_1004, 1'b1, 3'b010, 32'hA5A5_1234, 3, 2'b00, 32'h0, 1'b1, 4'b0010, 4'b1111);
        slv_wait = 3;
        xfer("rd_wait3", 32'h0000_3000, 1'b0, 3'b010, 32'h0, 6, 2'b00, 32'hDEAD_BEEF, 1'b1, 4'b1000, 4'b0000);
        slv_wait = 0;
        xfer("wr_byte", 32'h0000_0002, 1'b1, 3'b000, 32'h00AB_0000, 3, 2'b00, 32'hDEAD_BEEF, 1'b1, 4'b0001, 4'b0100);
        xfer("hw_misalign", 32'h0000_0001, 1'b1, 3'b001, 32'h0000_1234, 2, 2'b01, 32'hDEAD_BEEF, 1'b0, 4'b0000, 4'b0000);
        xfer("after_err_byte", 32'h0000_1003, 1'b1, 3'b000, 32'hCC00_0000, 3, 2'b00, 32'hDEAD_BEEF, 1'b1, 4'b0010, 4'b1000);
        xfer("rd_slv2", 32'h0000_2008, 1'b0, 3'b010, 32'h0, 3, 2'b00, 32'h2222_5555, 1'b1, 4'b0100, 4'b0000);
        xfer("wr_half_hi", 32'h0000_0102, 1'b1, 3'b001, 32'h5678_0000, 3, 2'b00, 32'h2222_5555, 1'b1, 4'b0001, 4'b1100);
        xfer("bad_idx", 32'h0000_5000, 1'b0, 3'b010, 32'h0, 2, 2'b01, 32'h2222_5555, 1'b0, 4'b0000, 4'b0000);
        xfer("bad_size", 32'h0000_0000, 1'b0, 3'b011, 32'h0, 2, 2'b01, 32'h2222_5555, 1'b0, 4'b0000, 4'b0000);
        PSLVERR = 4'b1111;
        xfer("slverr", 32'h0000_2000, 1'b0, 3'b010, 32'h0, 4, 2'b01, 32'h2222_5555, 1'b1, 4'b0100, 4'b0000);
        PSLVERR = 4'b0000;

        // BUSY transfers must be ignored
        HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h0000_1000; HWRITE = 1'b0; HSIZE = 3'b010;
        repeat (2) begin @(posedge HCLK); #1; end
        HSEL = 1'b0; HTRANS = 2'b00;
        chk("busy_ignored/hreadyout", {31'd0, HREADYOUT}, 32'd1);

        slv_wait = 1000;
        xfer("timeout", 32'h0000_1000, 1'b0, 3'b010, 32'h0, 11, 2'b01, 32'h2222_5555, 1'b1, 4'b0010, 4'b0000);
        chk("timeout/access_cycles", acc_len, 32'd8);

        // Reset in the middle of a stalled ACCESS
        p.name = "rst_mid"; p.psel = 4'b1000; p.paddr = 32'h0000_3004; p.pwrite = 1'b1;
        p.pstrb = 4'b1111; p.pwdata = 32'h0000_0077;
        apb_q.push_back(p);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_3004; HWRITE = 1'b1; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0000_0077;
        g = 0;
        while (!PENABLE && g < 20) begin @(posedge HCLK); #1; g++; end
        chk("rst_mid/reached_access", {31'd0, PENABLE}, 32'd1);
        repeat (2) begin @(posedge HCLK); #1; end
        HRESET = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        chk_reset_outputs("rst_mid");
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        slv_wait = 0;
        xfer("rd_after_rst", 32'h0000_3000, 1'b0, 3'b010, 32'h0, 3, 2'b00, 32'hDEAD_BEEF, 1'b1, 4'b1000, 4'b0000);

        repeat (5) @(posedge HCLK);
        chk("end/ahb_queue_left", ahb_q.size(), 32'd0);
        chk("end/apb_queue_left", apb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
